bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the three-digit seven-segment decoder.
- Converts a byte (for example, an AES state/ciphertext byte selected for display) into three packed BCD digits.
- Its bcd_out drives the decoder's 12-bit word input; bcd_out is held stable between conversions so the display never flickers.

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_add3.sv | 16 +
 rtl/bin_to_bcd_seq.sv | 85 ++++++++
 tb/tb_bin_to_bcd_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the binary-to-BCD converter.
package bcd_pkg;

  localparam int              BCD_DIGIT_W = 4;
  localparam logic [3:0]      ADD3_THRESH = 4'd5;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Smallest digit count whose decimal range covers every IN_W-bit value.
  function automatic int min_digits(input int in_w);
    longint unsigned max_val;
    longint unsigned p;
    int              d;
    max_val = (64'd1 << in_w) - 64'd1;
    p       = 64'd10;
    d       = 1;
    for (int i = 0; i < 20; i++) begin
      if (p <= max_val) begin
        d++;
        p = p * 64'd10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble corrector: digits of 5 or more get +3 so the
// following left shift carries into the next decimal digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_in,
  output logic [BCD_DIGIT_W-1:0] d_out
);

  // Combinational add-3 correction, wraps mod 16.
  always_comb begin
    d_out = d_in;
    if (d_in >= ADD3_THRESH) d_out = d_in + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// bcd_out is only written on the completing edge, so the downstream
// seven-segment decoder never sees a partial result.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [IN_W-1:0]               bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  if (DIGITS < min_digits(IN_W)) begin : g_digits_check
    $error("bin_to_bcd_seq: DIGITS too small for IN_W");
  end

  state_t           state;
  logic [IN_W-1:0]  bin_shift;
  logic [BCD_W-1:0] bcd_work;
  logic [BCD_W-1:0] bcd_corr;
  logic [BCD_W-1:0] bcd_next;
  logic [CNT_W-1:0] cnt;

  // One corrector per working digit, applied before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .d_in  (bcd_work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_out (bcd_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Corrected value shifted left; binary MSB enters digit 0 LSB.
  // The corrected MSB falls off; it is always zero given the DIGITS check.
  always_comb begin
    bcd_next = (bcd_corr << 1) | BCD_W'(bin_shift[IN_W-1]);
  end

  // Control FSM with counter, working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      bcd_work  <= '0;
      bin_shift <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bin_shift <= bin_in;
            bcd_work  <= '0;
            cnt       <= CNT_W'(IN_W);
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_work  <= bcd_next;
          bin_shift <= bin_shift << 1;
          cnt       <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            bcd_out <= bcd_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: table-driven conversions plus
// hand-written back-to-back, disturbance and mid-conversion reset cases.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
  } vec_t;

  vec_t vecs [8];

  bin_to_bcd_seq #(.IN_W(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Accept one conversion and walk it edge by edge.
  task automatic run_conv(input logic [7:0] b, input logic [11:0] exp);
    logic [11:0] prev;
    int          bad;
    prev   = bcd_out;
    bin_in = b;
    start  = 1'b1;
    tick();                                  // accept edge E
    start  = 1'b0;
    bin_in = 8'hA5;                          // must be ignored
    bad    = 0;
    for (int k = 1; k < 8; k++) begin
      if (k == 1) chk("busy_after_accept", {31'd0, busy}, 32'd1);
      tick();
      if (busy !== 1'b1 || done !== 1'b0 || bcd_out !== prev) bad++;
    end
    chk("shift_phase_stable", bad, 0);
    tick();                                  // edge E+8
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_clear", {31'd0, busy}, 32'd0);
    chk($sformatf("bcd_%0d", b), {20'd0, bcd_out}, {20'd0, exp});
    tick();
    chk("done_single", {31'd0, done}, 32'd0);
    chk("bcd_hold", {20'd0, bcd_out}, {20'd0, exp});
  endtask

  initial begin
    int          ndone;
    int          t_done [2];
    logic [11:0] r_done [2];

    vecs[0] = '{8'd0,   12'h000};
    vecs[1] = '{8'd255, 12'h255};
    vecs[2] = '{8'd128, 12'h128};
    vecs[3] = '{8'd99,  12'h099};
    vecs[4] = '{8'd10,  12'h010};
    vecs[5] = '{8'd1,   12'h001};
    vecs[6] = '{8'd100, 12'h100};
    vecs[7] = '{8'd59,  12'h059};

    // Reset then idle
    rst = 1'b1; start = 1'b0; bin_in = 8'd0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bcd",  {20'd0, bcd_out}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      bin_in = 8'(k * 13);
      tick();
      if (done === 1'b1 || busy !== 1'b0) ndone++;
    end
    chk("idle_quiet", ndone, 0);
    chk("idle_bcd", {20'd0, bcd_out}, 32'd0);

    // Table-driven conversions
    for (int i = 0; i < 8; i++) run_conv(vecs[i].bin, vecs[i].bcd);

    // Start held high: 37 then 200, done 9 edges apart
    start = 1'b1; bin_in = 8'd37;
    tick();                                  // accept edge E
    bin_in = 8'd200;
    ndone = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (done === 1'b1) begin
        if (ndone < 2) begin
          t_done[ndone] = k;
          r_done[ndone] = bcd_out;
        end
        ndone++;
      end
    end
    start = 1'b0;
    chk("b2b_count", ndone, 2);
    if (ndone >= 2) begin
      chk("b2b_first_edge", t_done[0], 8);
      chk("b2b_first_bcd", {20'd0, r_done[0]}, 32'h037);
      chk("b2b_gap", t_done[1] - t_done[0], 9);
      chk("b2b_second_bcd", {20'd0, r_done[1]}, 32'h200);
    end
    tick(); tick();
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    // Disturbance during SHIFT
    start = 1'b1; bin_in = 8'd42;
    tick();
    bin_in = 8'd7;
    ndone = 0;
    for (int k = 1; k <= 8; k++) begin
      start = k[0];
      tick();
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    chk("dist_bcd", {20'd0, bcd_out}, 32'h042);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("dist_single_done", ndone, 1);
    chk("dist_idle", {31'd0, busy}, 32'd0);

    // Reset on the 4th SHIFT edge
    start = 1'b1; bin_in = 8'd173;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_bcd", {20'd0, bcd_out}, 32'h042);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_bcd", {20'd0, bcd_out}, 32'h000);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);
    run_conv(8'd173, 12'h173);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
